// File: rtl/adc_multi_chan_trig.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adc_multi_chan_trig                                           |
// | Description : Multi-source trigger unit for the FMC-ADC acquisition core.  |
// |               Merges N per-channel threshold/hysteresis detectors, a       |
// |               software trigger and a delayed external trigger into one     |
// |               trigger pulse, followed by a programmable hold-off window.   |
// | Option      : ADC_TRIG_CNT_EN - builds the 32-bit accepted-trigger counter;|
// |               when undefined trig_cnt_o is tied to zero.                   |
// | Ports       : sys_clk_i/sys_rst_n_i  clock, async active-low reset         |
// |               data_i/data_valid_i    signed samples (ch0 in LSBs) + strobe |
// |               thres_val_i/thres_hyst_i/ch_pol_i  per-channel detector cfg  |
// |               trig_en_i              source enables (0 sw, 1 ext, 2+k ch k)|
// |               arm_i                  acceptance level                      |
// |               sw_trig_i/ext_trig_i/ext_dly_i  sw and delayed ext triggers  |
// |               holdoff_i              hold-off length in cycles             |
// |               trig_o/trig_src_o/trig_cnt_o  pulse, source record, count    |
// | Revision    : 1.0 - initial parametrised release                           |
// +----------------------------------------------------------------------------+
module adc_multi_chan_trig #(
  parameter int G_NUM_CH    = 4,
  parameter int G_DATA_W    = 16,
  parameter int G_DLY_W     = 32,
  parameter int G_HOLDOFF_W = 16
) (
  input  logic                         sys_clk_i,
  input  logic                         sys_rst_n_i,
  input  logic [G_NUM_CH*G_DATA_W-1:0] data_i,
  input  logic                         data_valid_i,
  input  logic [G_NUM_CH*G_DATA_W-1:0] thres_val_i,
  input  logic [G_NUM_CH*G_DATA_W-1:0] thres_hyst_i,
  input  logic [G_NUM_CH-1:0]          ch_pol_i,
  input  logic [G_NUM_CH+1:0]          trig_en_i,
  input  logic                         arm_i,
  input  logic                         sw_trig_i,
  input  logic                         ext_trig_i,
  input  logic [G_DLY_W-1:0]           ext_dly_i,
  input  logic [G_HOLDOFF_W-1:0]       holdoff_i,
  output logic                         trig_o,
  output logic [G_NUM_CH+1:0]          trig_src_o,
  output logic [31:0]                  trig_cnt_o
);

  // Two guard bits: thres +/- hyst can never overflow for any input values.
  localparam int CW = G_DATA_W + 2;

  logic [G_NUM_CH-1:0] ch_fire;

  // ---------------------------------------------------------------------------
  // Per-channel threshold detectors (free running, independent of arm/enable)
  // ---------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < G_NUM_CH; k++) begin : g_ch
      logic signed [CW-1:0] sample;
      logic signed [CW-1:0] thres;
      logic signed [CW-1:0] hyst;
      logic signed [CW-1:0] lo_lim;
      logic signed [CW-1:0] hi_lim;
      logic                 arm_cond;
      logic                 fire_cond;
      logic                 armed;

      assign sample = {{2{data_i[k*G_DATA_W+G_DATA_W-1]}}, data_i[k*G_DATA_W +: G_DATA_W]};
      assign thres  = {{2{thres_val_i[k*G_DATA_W+G_DATA_W-1]}}, thres_val_i[k*G_DATA_W +: G_DATA_W]};
      assign hyst   = {2'b00, thres_hyst_i[k*G_DATA_W +: G_DATA_W]};
      assign lo_lim = thres - hyst;
      assign hi_lim = thres + hyst;

      // Falling polarity mirrors the rising detector around the threshold.
      assign arm_cond   = ch_pol_i[k] ? (sample > hi_lim) : (sample < lo_lim);
      assign fire_cond  = ch_pol_i[k] ? (sample <= thres) : (sample >= thres);
      assign ch_fire[k] = data_valid_i & armed & fire_cond;

      always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
          armed <= 1'b0;
        end else if (data_valid_i) begin
          if (armed) begin
            if (fire_cond) armed <= 1'b0;
          end else if (arm_cond) begin
            armed <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // External trigger: edge detect, then count ext_dly_i cycles down to zero.
  // ---------------------------------------------------------------------------
  logic               ext_prev;
  logic               ext_pend;
  logic [G_DLY_W-1:0] ext_cnt;
  logic               ext_fire;

  assign ext_fire = ext_pend && (ext_cnt == '0);

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      ext_prev <= 1'b0;
      ext_pend <= 1'b0;
      ext_cnt  <= '0;
    end else begin
      ext_prev <= ext_trig_i;
      if (!arm_i) begin
        ext_pend <= 1'b0;
      end else if (ext_pend) begin
        // New edges are ignored until the pending delay has expired.
        if (ext_cnt == '0) ext_pend <= 1'b0;
        else               ext_cnt  <= ext_cnt - G_DLY_W'(1);
      end else if (ext_trig_i && !ext_prev) begin
        ext_pend <= 1'b1;
        ext_cnt  <= ext_dly_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Global trigger FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READY   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t                 state;
  logic [G_HOLDOFF_W-1:0] hold_cnt;
  logic [G_NUM_CH+1:0]    fired;
  logic                   accept;

  assign fired  = trig_en_i & {ch_fire, ext_fire, sw_trig_i};
  assign accept = arm_i && (state == ST_READY) && (|fired);

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      trig_o     <= 1'b0;
      trig_src_o <= '0;
    end else begin
      trig_o <= 1'b0;
      if (!arm_i) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: state <= ST_READY;
          ST_READY: begin
            if (accept) begin
              trig_o     <= 1'b1;
              trig_src_o <= fired;
              hold_cnt   <= holdoff_i;
              state      <= (holdoff_i == '0) ? ST_READY : ST_HOLDOFF;
            end
          end
          ST_HOLDOFF: begin
            // hold_cnt starts at holdoff_i: exactly holdoff_i cycles spent here.
            if (hold_cnt <= G_HOLDOFF_W'(1)) state    <= ST_READY;
            else                             hold_cnt <= hold_cnt - G_HOLDOFF_W'(1);
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accepted-trigger counter (optional)
  // ---------------------------------------------------------------------------
`ifdef ADC_TRIG_CNT_EN
  logic [31:0] trig_cnt;

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i)  trig_cnt <= '0;
    else if (accept)   trig_cnt <= trig_cnt + 32'd1;
  end

  assign trig_cnt_o = trig_cnt;
`else
  assign trig_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_multi_chan_trig.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_adc_multi_chan_trig                                        |
// | Description : Directed self-checking bench for adc_multi_chan_trig.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_adc_multi_chan_trig;

  localparam int NCH  = 4;
  localparam int DW   = 16;
  localparam int DLYW = 32;
  localparam int HOW  = 16;
`ifdef ADC_TRIG_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH*DW-1:0] data;
  logic              data_valid;
  logic [NCH*DW-1:0] thres_val;
  logic [NCH*DW-1:0] thres_hyst;
  logic [NCH-1:0]    ch_pol;
  logic [NCH+1:0]    trig_en;
  logic              arm;
  logic              sw_trig;
  logic              ext_trig;
  logic [DLYW-1:0]   ext_dly;
  logic [HOW-1:0]    holdoff;
  logic              trig;
  logic [NCH+1:0]    trig_src;
  logic [31:0]       trig_cnt;

  int          errors  = 0;
  int          checks  = 0;
  logic [31:0] exp_cnt = 32'd0;

  always #5 clk = ~clk;

  adc_multi_chan_trig #(
    .G_NUM_CH(NCH), .G_DATA_W(DW), .G_DLY_W(DLYW), .G_HOLDOFF_W(HOW)
  ) dut (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n),
    .data_i(data), .data_valid_i(data_valid),
    .thres_val_i(thres_val), .thres_hyst_i(thres_hyst), .ch_pol_i(ch_pol),
    .trig_en_i(trig_en), .arm_i(arm), .sw_trig_i(sw_trig),
    .ext_trig_i(ext_trig), .ext_dly_i(ext_dly), .holdoff_i(holdoff),
    .trig_o(trig), .trig_src_o(trig_src), .trig_cnt_o(trig_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    check(tag, trig_cnt, CNT_ON ? exp_cnt : 32'd0);
  endtask

  // Outputs are sampled 1 ns after the active edge; inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    data[k*DW +: DW] = v;
  endtask

  task automatic set_thr(input int k, input logic [DW-1:0] t, input logic [DW-1:0] h);
    thres_val[k*DW +: DW]  = t;
    thres_hyst[k*DW +: DW] = h;
  endtask

  logic [DW-1:0] hv_dat [5];
  logic          hv_exp [5];
  int            nfire;
  int            pos;
  int            val;

  initial begin
    data = '0; thres_val = '0; thres_hyst = '0; data_valid = 1'b0; ch_pol = '0;
    trig_en = '0; arm = 1'b0; sw_trig = 1'b0; ext_trig = 1'b0; ext_dly = '0; holdoff = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_trig", trig, 0);
    check("rst_src", trig_src, 0);
    check("rst_cnt", trig_cnt, 0);
    rst_n = 1'b1;
    step();

    arm = 1'b1;
    step();
    step();

    // Software trigger: one cycle latency, single pulse
    trig_en = 6'h01;
    sw_trig = 1'b1;
    step();
    exp_cnt++;
    check("sw_trig", trig, 1);
    check("sw_src", trig_src, 6'h01);
    chk_cnt("sw_cnt");
    sw_trig = 1'b0;
    step();
    check("sw_single", trig, 0);

    // Hold-off 5: sw at 0,3,6 -> pulses at 1 and 7 only
    holdoff = 16'd5;
    for (int c = 0; c < 9; c++) begin
      sw_trig = (c == 0 || c == 3 || c == 6);
      step();
      check($sformatf("holdoff_c%0d", c + 1), trig, (c == 0 || c == 6));
    end
    sw_trig = 1'b0;
    exp_cnt += 2;
    chk_cnt("holdoff_cnt");
    holdoff = '0;
    repeat (6) step();

    // External delay 3, toggling input: first rise at 0 -> pulse at 5 only
    trig_en = 6'h02;
    ext_dly = 32'd3;
    for (int c = 0; c < 10; c++) begin
      ext_trig = (c == 0 || c == 2);
      step();
      check($sformatf("ext3_c%0d", c + 1), trig, (c == 4));
    end
    exp_cnt++;
    check("ext_src", trig_src, 6'h02);
    // External delay 0: rise at 0 -> pulse at 2
    ext_dly = 32'd0;
    for (int c = 0; c < 5; c++) begin
      ext_trig = (c == 0);
      step();
      check($sformatf("ext0_c%0d", c + 1), trig, (c == 1));
    end
    exp_cnt++;
    chk_cnt("ext_cnt");

    // Channel 0 rising, thres 0x300 hyst 0x100, triangle +-0x400 step 8
    trig_en = 6'h04;
    set_thr(0, 16'h0300, 16'h0100);
    data_valid = 1'b1;
    for (int p = 0; p < 2; p++) begin
      nfire = 0;
      pos = -1;
      for (int i = 0; i < 512; i++) begin
        val = (i < 256) ? (-1024 + 8 * i) : (1024 - 8 * (i - 256));
        set_ch(0, DW'(val));
        step();
        if (trig) begin
          nfire++;
          pos = i;
        end
      end
      check($sformatf("tri_p%0d_count", p), nfire, 1);
      check($sformatf("tri_p%0d_pos", p), pos, 224);
    end
    exp_cnt += 2;
    check("tri_src", trig_src, 6'h04);

    // Hysteresis boundary: no re-arm at exactly 0x200, re-arm at 0x1FF
    hv_dat[0] = 16'h0300; hv_exp[0] = 1'b1;
    hv_dat[1] = 16'h0200; hv_exp[1] = 1'b0;
    hv_dat[2] = 16'h0300; hv_exp[2] = 1'b0;
    hv_dat[3] = 16'h01FF; hv_exp[3] = 1'b0;
    hv_dat[4] = 16'h0300; hv_exp[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_ch(0, hv_dat[i]);
      step();
      check($sformatf("hyst_v%0d", i), trig, hv_exp[i]);
    end
    exp_cnt += 2;

    // data_valid low freezes the detector
    set_ch(0, 16'h0100);
    step();
    set_ch(0, 16'h0300);
    data_valid = 1'b0;
    step();
    check("valid_lo_1", trig, 0);
    step();
    check("valid_lo_2", trig, 0);
    data_valid = 1'b1;
    step();
    check("valid_hi", trig, 1);
    exp_cnt++;

    // Channel 1 falling, thres 0, hyst 0x10
    trig_en = 6'h08;
    ch_pol  = 4'b0010;
    set_thr(1, 16'h0000, 16'h0010);
    hv_dat[0] = 16'h0010; hv_exp[0] = 1'b0;
    hv_dat[1] = 16'h0011; hv_exp[1] = 1'b0;
    hv_dat[2] = 16'h0005; hv_exp[2] = 1'b0;
    hv_dat[3] = 16'h0000; hv_exp[3] = 1'b1;
    hv_dat[4] = 16'hFFF0; hv_exp[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_ch(1, hv_dat[i]);
      step();
      check($sformatf("fall_v%0d", i), trig, hv_exp[i]);
    end
    exp_cnt++;
    check("fall_src", trig_src, 6'h08);

    // Channel 3 extreme thres/hyst: low limit is below every sample, never arms
    trig_en = 6'h20;
    set_thr(3, 16'h8000, 16'hFFFF);
    set_ch(3, 16'h8000);
    step();
    check("wrap_lo", trig, 0);
    set_ch(3, 16'h7FFF);
    step();
    check("wrap_hi", trig, 0);
    chk_cnt("wrap_cnt");

    // Simultaneous sw + channel 2 crossing
    trig_en = 6'h11;
    set_thr(2, 16'h0100, 16'h0010);
    set_ch(2, 16'hFF00);
    step();
    set_ch(2, 16'h0100);
    sw_trig = 1'b1;
    step();
    sw_trig = 1'b0;
    exp_cnt++;
    check("simul_trig", trig, 1);
    check("simul_src", trig_src, 6'h11);
    chk_cnt("simul_cnt");
    step();
    check("simul_single", trig, 0);

    // Brief disarm cancels a pending external delay
    data_valid = 1'b0;
    trig_en = 6'h02;
    ext_dly = 32'd5;
    for (int c = 0; c < 10; c++) begin
      ext_trig = (c == 0);
      arm = (c != 1);
      step();
      check($sformatf("cancel_c%0d", c + 1), trig, 0);
    end
    // Disarmed: software trigger not accepted; record and count retained
    trig_en = 6'h01;
    arm = 1'b0;
    sw_trig = 1'b1;
    step();
    check("disarm_sw1", trig, 0);
    step();
    check("disarm_sw2", trig, 0);
    sw_trig = 1'b0;
    check("disarm_src", trig_src, 6'h11);
    chk_cnt("disarm_cnt");

    // Counter wrap-around
    arm = 1'b1;
    step();
    step();
`ifdef ADC_TRIG_CNT_EN
    force dut.trig_cnt = 32'hFFFF_FFFE;
    step();
    release dut.trig_cnt;
    exp_cnt = 32'hFFFF_FFFE;
`endif
    sw_trig = 1'b1;
    step();
    exp_cnt++;
    check("cntwrap_t1", trig, 1);
    chk_cnt("cntwrap_1");
    step();
    exp_cnt++;
    check("cntwrap_t2", trig, 1);
    chk_cnt("cntwrap_2");
    sw_trig = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
